// File: rtl/imem_responder_if.sv
// Fetch + boot-loader bundle between the PC/loader side (master) and the instruction memory (slave).
// Fetch: ce, addr -> inst, inst_valid, fetch_err (combinational return).
// Loader: ld_valid, ld_byte, ld_last -> ld_busy, ld_words, ld_ovf (no backpressure; every strobed byte is taken).
interface imem_responder_if #(
  parameter int AW = 10
);
  logic          ce;
  logic [31:0]   addr;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          fetch_err;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_busy;
  logic [AW:0]   ld_words;
  logic          ld_ovf;

  modport master (
    output ce, addr, ld_valid, ld_byte, ld_last,
    input  inst, inst_valid, fetch_err, ld_busy, ld_words, ld_ovf
  );

  modport slave (
    input  ce, addr, ld_valid, ld_byte, ld_last,
    output inst, inst_valid, fetch_err, ld_busy, ld_words, ld_ovf
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with a byte-serial boot-loader that packs little-endian bytes into words from index 0.
// Latency: fetch is combinational (zero cycles from addr); loader writes land one clock after the completing byte.
// Backpressure: none; the loader accepts one byte per ld_valid cycle, and fetches return NOP while a load runs.
// Ports: clk/rst (sync, active-high); bus.slave carries fetch (ce, addr, inst, inst_valid, fetch_err)
// and loader (ld_valid, ld_byte, ld_last, ld_busy, ld_words, ld_ovf). The interface AW must match this AW.
module imem_responder #(
  parameter int          AW  = 10,
  parameter logic [31:0] NOP = 32'h00000013
) (
  input logic               clk,
  input logic               rst,
  imem_responder_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [1:0]      r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0]     r_asm, w_asm_nxt;
  logic [AW:0]     r_ld_words, w_ld_words_nxt;
  logic            r_ld_ovf, w_ld_ovf_nxt;
  logic            r_ld_busy;

  // Per-byte starting point: a byte seen in RUN starts a fresh image.
  logic [31:0]     w_asm_base;
  logic [1:0]      w_cnt_base;
  logic [AW-1:0]   w_ptr_base;
  logic [AW:0]     w_words_base;
  logic            w_ovf_base;
  logic [31:0]     w_merged;
  logic            w_word_done;

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [31:0]     w_wdata;

  logic            w_addr_ok;
  logic            w_fetch_ok;

  logic [31:0]     r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_ld_words <= '0;
      r_ld_ovf   <= 1'b0;
      r_ld_busy  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_asm      <= w_asm_nxt;
      r_ld_words <= w_ld_words_nxt;
      r_ld_ovf   <= w_ld_ovf_nxt;
      r_ld_busy  <= (w_state_nxt == LOAD);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_asm_nxt      = r_asm;
    w_ld_words_nxt = r_ld_words;
    w_ld_ovf_nxt   = r_ld_ovf;
    w_asm_base     = r_asm;
    w_cnt_base     = r_byte_cnt;
    w_ptr_base     = r_wr_ptr;
    w_words_base   = r_ld_words;
    w_ovf_base     = r_ld_ovf;
    w_merged       = '0;
    w_word_done    = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_wr_ptr;
    w_wdata        = '0;

    if (r_state == RUN) begin
      w_asm_base   = '0;
      w_cnt_base   = '0;
      w_ptr_base   = '0;
      w_words_base = '0;
      w_ovf_base   = 1'b0;
    end

    if (bus.ld_valid) begin
      w_merged       = w_asm_base | ({24'b0, bus.ld_byte} << {w_cnt_base, 3'b000});
      // ld_last flushes a partial word; a full lane-3 word with ld_last is still one write.
      w_word_done    = (w_cnt_base == 2'd3) || bus.ld_last;
      w_state_nxt    = LOAD;
      w_byte_cnt_nxt = w_cnt_base + 2'd1;
      w_asm_nxt      = w_merged;
      w_wr_ptr_nxt   = w_ptr_base;
      w_ld_words_nxt = w_words_base;
      w_ld_ovf_nxt   = w_ovf_base;
      if (w_word_done) begin
        w_asm_nxt = '0;
        // Array full: drop the word rather than wrapping onto index 0.
        if (w_words_base == DEPTH) begin
          w_ld_ovf_nxt = 1'b1;
        end else begin
          w_we           = 1'b1;
          w_waddr        = w_ptr_base;
          w_wdata        = w_merged;
          w_wr_ptr_nxt   = w_ptr_base + AW'(1);
          w_ld_words_nxt = w_words_base + (AW+1)'(1);
        end
      end
      if (bus.ld_last) begin
        w_state_nxt    = RUN;
        w_byte_cnt_nxt = '0;
        w_wr_ptr_nxt   = '0;
      end
    end
  end

  // Array is deliberately not reset; a reset cycle never writes.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_addr_ok  = (bus.addr[1:0] == 2'b00) && (bus.addr[31:AW+2] == '0);
  assign w_fetch_ok = (r_state == RUN) && bus.ce && w_addr_ok;

  assign bus.inst       = w_fetch_ok ? r_mem[bus.addr[AW+1:2]] : NOP;
  assign bus.inst_valid = w_fetch_ok;
  assign bus.fetch_err  = bus.ce && !w_addr_ok;
  assign bus.ld_busy    = r_ld_busy;
  assign bus.ld_words   = r_ld_words;
  assign bus.ld_ovf     = r_ld_ovf;

endmodule
